set_mode_ctrl: RTL and testbench

Key-driven time-setting controller for the clock board. It consumes the two debounced, active-low key levels produced by the debouncer stage (MODE and ADJ) on the same 40 Hz sample clock. It sequences the RUN/SET_HOUR/SET_MIN/SET_SEC modes and emits single-cycle adjust strobes, with long-press auto-repeat, inactivity timeout and a display blink flag, to the timekeeping counters and the display mux.

---
 rtl/set_mode_ctrl.sv | 152 +++++++++++++++
 tb/tb_set_mode_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl: key-driven time-setting controller for the clock board.
// MODE walks the edit fields; ADJ strobes with auto-repeat, timeout, blink.
module set_mode_ctrl #(
  parameter int HOLD_TICKS    = 40,
  parameter int REPEAT_TICKS  = 8,
  parameter int TIMEOUT_TICKS = 400,
  parameter int BLINK_TICKS   = 10
) (
  input  logic       sample_clk,
  input  logic       Reset_N,
  input  logic       key_mode,
  input  logic       key_adj,
  output logic [1:0] mode,
  output logic       run_en,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ?
                        HOLD_TICKS : REPEAT_TICKS;
  localparam int HW = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam int TW = (TIMEOUT_TICKS > 1) ?
                      $clog2(TIMEOUT_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ?
                      $clog2(BLINK_TICKS) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);
  localparam logic [BW-1:0] BL_LAST   = BW'(BLINK_TICKS - 1);

  mode_t          r_mode;
  logic           r_run_en;
  logic           r_inc_hour;
  logic           r_inc_min;
  logic           r_clr_sec;
  logic           r_blink;
  logic           r_mode_q;
  logic           r_adj_q;
  logic           r_hold_act;
  logic           r_hold_rep;
  logic [HW-1:0]  r_hold_cnt;
  logic [TW-1:0]  r_tcnt;
  logic [BW-1:0]  r_bcnt;

  logic           w_mode_press;
  logic           w_adj_press;
  logic           w_in_set;
  logic [HW-1:0]  w_rep_last;
  logic           w_repeat;
  logic           w_strobe;
  logic           w_timeout;
  mode_t          w_mode_next;

  assign w_mode_press = r_mode_q & ~key_mode;
  // MODE wins a same-edge collision; that ADJ edge is consumed
  assign w_adj_press  = r_adj_q & ~key_adj & ~w_mode_press;
  assign w_in_set     = (r_mode != RUN);
  assign w_rep_last   = r_hold_rep ? REP_LAST : HOLD_LAST;
  assign w_repeat     = r_hold_act & ~key_adj &
                        (r_hold_cnt == w_rep_last);
  assign w_strobe     = (w_adj_press & w_in_set) | w_repeat;
  assign w_timeout    = w_in_set & (r_tcnt == TO_LAST);
  assign w_mode_next  = mode_t'(r_mode + 2'd1);

  always_ff @(posedge sample_clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_mode     <= RUN;
      r_run_en   <= 1'b1;
      r_inc_hour <= 1'b0;
      r_inc_min  <= 1'b0;
      r_clr_sec  <= 1'b0;
      r_blink    <= 1'b0;
      r_mode_q   <= 1'b1;
      r_adj_q    <= 1'b1;
      r_hold_act <= 1'b0;
      r_hold_rep <= 1'b0;
      r_hold_cnt <= '0;
      r_tcnt     <= '0;
      r_bcnt     <= '0;
    end else begin
      r_mode_q   <= key_mode;
      r_adj_q    <= key_adj;
      r_inc_hour <= 1'b0;
      r_inc_min  <= 1'b0;
      r_clr_sec  <= 1'b0;
      if (w_mode_press) begin
        r_mode     <= w_mode_next;
        r_run_en   <= (w_mode_next == RUN);
        r_hold_act <= 1'b0;
        r_hold_rep <= 1'b0;
        r_hold_cnt <= '0;
        r_tcnt     <= '0;
        r_bcnt     <= '0;
        r_blink    <= (w_mode_next != RUN);
      end else if (w_strobe) begin
        r_inc_hour <= (r_mode == SET_HOUR);
        r_inc_min  <= (r_mode == SET_MIN);
        r_clr_sec  <= (r_mode == SET_SEC);
        r_hold_act <= (r_mode != SET_SEC);
        r_hold_rep <= w_repeat;
        r_hold_cnt <= '0;
        r_tcnt     <= '0;
        r_bcnt     <= '0;
        r_blink    <= 1'b1;
      end else if (w_timeout) begin
        r_mode     <= RUN;
        r_run_en   <= 1'b1;
        r_hold_act <= 1'b0;
        r_hold_rep <= 1'b0;
        r_hold_cnt <= '0;
        r_tcnt     <= '0;
        r_bcnt     <= '0;
        r_blink    <= 1'b0;
      end else begin
        if (key_adj) begin
          r_hold_act <= 1'b0;
          r_hold_rep <= 1'b0;
          r_hold_cnt <= '0;
        end else if (r_hold_act) begin
          r_hold_cnt <= r_hold_cnt + HW'(1);
        end
        if (w_in_set) begin
          r_tcnt <= r_tcnt + TW'(1);
          if (r_bcnt == BL_LAST) begin
            r_bcnt  <= '0;
            r_blink <= ~r_blink;
          end else begin
            r_bcnt <= r_bcnt + BW'(1);
          end
        end
      end
    end
  end

  assign mode     = r_mode;
  assign run_en   = r_run_en;
  assign inc_hour = r_inc_hour;
  assign inc_min  = r_inc_min;
  assign clr_sec  = r_clr_sec;
  assign blink    = r_blink;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// tb_set_mode_ctrl: directed and random checks of set_mode_ctrl
// against an edge-indexed behavioural model.
module tb_set_mode_ctrl;

  localparam int HOLD = 40;
  localparam int REP  = 8;
  localparam int TMO  = 400;
  localparam int BLK  = 10;

  logic       sample_clk = 1'b0;
  logic       Reset_N    = 1'b0;
  logic       key_mode   = 1'b1;
  logic       key_adj    = 1'b1;
  logic [1:0] mode;
  logic       run_en;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic       blink;
  logic [6:0] dv;

  int tests = 0;
  int fails = 0;

  int m_mode;
  int n = 0;
  int m_k;
  int m_last;
  int m_bref;
  bit m_pm;
  bit m_pa;
  bit m_hold;
  bit e_hour;
  bit e_min;
  bit e_sec;

  localparam logic [6:0] RST_VEC = 7'b00_1_000_0;

  set_mode_ctrl #(
    .HOLD_TICKS(HOLD),
    .REPEAT_TICKS(REP),
    .TIMEOUT_TICKS(TMO),
    .BLINK_TICKS(BLK)
  ) dut (
    .sample_clk(sample_clk),
    .Reset_N(Reset_N),
    .key_mode(key_mode),
    .key_adj(key_adj),
    .mode(mode),
    .run_en(run_en),
    .inc_hour(inc_hour),
    .inc_min(inc_min),
    .clr_sec(clr_sec),
    .blink(blink)
  );

  assign dv = {mode, run_en, inc_hour, inc_min, clr_sec, blink};

  always #10 sample_clk = ~sample_clk;

  function automatic bit e_blink();
    return (m_mode != 0) && (((n - m_bref) / BLK) % 2 == 0);
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [1:0] mm;
    mm = 2'(m_mode);
    return {mm, m_mode == 0, e_hour, e_min, e_sec, e_blink()};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pm   = 1'b1;
    m_pa   = 1'b1;
    m_hold = 1'b0;
    e_hour = 1'b0;
    e_min  = 1'b0;
    e_sec  = 1'b0;
    m_last = n;
    m_bref = n;
    m_k    = n;
  endtask

  // One sample edge described in terms of press times and elapsed edges
  task automatic model_edge(input bit km, input bit ka);
    bit mp;
    bit ap;
    bit rep;
    n++;
    mp  = !km && m_pm;
    ap  = !ka && m_pa && !mp;
    rep = m_hold && !ka && (n - m_k) >= HOLD &&
          ((n - m_k - HOLD) % REP) == 0;
    e_hour = 1'b0;
    e_min  = 1'b0;
    e_sec  = 1'b0;
    if (mp) begin
      m_mode = (m_mode + 1) % 4;
      m_hold = 1'b0;
      m_last = n;
      m_bref = n;
    end else if ((ap && m_mode != 0) || rep) begin
      e_hour = (m_mode == 1);
      e_min  = (m_mode == 2);
      e_sec  = (m_mode == 3);
      m_last = n;
      m_bref = n;
      if (ap) begin
        m_k    = n;
        m_hold = (m_mode == 1 || m_mode == 2);
      end
    end else if (m_mode != 0 && n - m_last == TMO) begin
      m_mode = 0;
      m_hold = 1'b0;
    end else if (ka) begin
      m_hold = 1'b0;
    end
    m_pm = km;
    m_pa = ka;
  endtask

  task automatic tick(input bit km, input bit ka);
    key_mode = km;
    key_adj  = ka;
    @(posedge sample_clk);
    model_edge(km, ka);
    #1;
  endtask

  task automatic test_reset();
    Reset_N  = 1'b0;
    key_mode = 1'b1;
    key_adj  = 1'b1;
    model_reset();
    repeat (3) @(posedge sample_clk);
    #1;
    tests++;
    if (dv !== RST_VEC) begin
      fails++;
      $display("FAIL reset: got %b want %b", dv, RST_VEC);
    end
    Reset_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      tests++;
      if (dv !== exp_vec()) begin
        fails++;
        $display("FAIL reset_idle %0d: got %b want %b",
                 i, dv, exp_vec());
      end
    end
  endtask

  task automatic test_mode_cycle();
    int want[4] = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1);
      tests++;
      if (mode !== 2'(want[i]) || blink !== (want[i] != 0) ||
          run_en !== (want[i] == 0) || dv !== exp_vec()) begin
        fails++;
        $display("FAIL mode_cycle %0d: got %b want mode %0d",
                 i, dv, want[i]);
      end
      tick(1'b1, 1'b1);
      tests++;
      if (dv !== exp_vec()) begin
        fails++;
        $display("FAIL mode_release %0d: got %b want %b",
                 i, dv, exp_vec());
      end
    end
  endtask

  task automatic test_hold_repeat();
    int at[$];
    int other;
    other = 0;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 60; i++) begin
      tick(1'b1, 1'b0);
      if (inc_hour === 1'b1) at.push_back(i);
      if (inc_min !== 1'b0 || clr_sec !== 1'b0) other++;
      tests++;
      if (dv !== exp_vec()) begin
        fails++;
        $display("FAIL hold cyc %0d: got %b want %b",
                 i, dv, exp_vec());
      end
    end
    tick(1'b1, 1'b1);
    tests++;
    if (at.size() != 4 || at[0] != 0 || at[1] != 40 ||
        at[2] != 48 || at[3] != 56 || other != 0) begin
      fails++;
      $display("FAIL hold_times: got %p (other %0d) want 0,40,48,56",
               at, other);
    end
  endtask

  task automatic test_sec_no_repeat();
    int cnt;
    cnt = 0;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tests++;
    if (mode !== 2'd3) begin
      fails++;
      $display("FAIL sec_entry: got mode %0d want 3", mode);
    end
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 1'b0);
      if (clr_sec === 1'b1) cnt++;
      tests++;
      if (dv !== exp_vec()) begin
        fails++;
        $display("FAIL sec cyc %0d: got %b want %b",
                 i, dv, exp_vec());
      end
    end
    tick(1'b1, 1'b1);
    tests++;
    if (cnt != 1) begin
      fails++;
      $display("FAIL sec_count: got %0d want 1", cnt);
    end
  endtask

  task automatic test_timeout();
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    for (int j = 1; j <= 400; j++) begin
      tick(1'b1, 1'b1);
      tests++;
      if (dv !== exp_vec() ||
          (j < 400 && mode !== 2'd2) ||
          (j == 400 && (mode !== 2'd0 || run_en !== 1'b1))) begin
        fails++;
        $display("FAIL timeout idle %0d: got %b want %b",
                 j, dv, exp_vec());
      end
    end
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    for (int j = 1; j < 400; j++) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tests++;
    if (mode !== 2'd2 || inc_min !== 1'b1 || dv !== exp_vec()) begin
      fails++;
      $display("FAIL timeout_press: got %b want mode 2 + inc_min", dv);
    end
    for (int j = 1; j <= 400; j++) begin
      tick(1'b1, 1'b1);
      tests++;
      if (dv !== exp_vec() ||
          (j < 400 && mode !== 2'd2) ||
          (j == 400 && mode !== 2'd0)) begin
        fails++;
        $display("FAIL timeout_restart %0d: got %b want %b",
                 j, dv, exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    int bad;
    bad = 0;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tests++;
    if (mode !== 2'd2 || inc_hour !== 1'b0 || inc_min !== 1'b0) begin
      fails++;
      $display("FAIL simul_press: got %b want mode 2 no strobe", dv);
    end
    for (int i = 0; i < 60; i++) begin
      tick(1'b1, 1'b0);
      if (inc_min !== 1'b0 || inc_hour !== 1'b0) bad++;
      if (dv !== exp_vec()) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL simul_hold: got %0d bad cycles want 0", bad);
    end
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tests++;
    if (inc_min !== 1'b1 || dv !== exp_vec()) begin
      fails++;
      $display("FAIL simul_repress: got %b want %b", dv, exp_vec());
    end
    tick(1'b1, 1'b1);
  endtask

  task automatic test_reset_midhold();
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
    end
    tests++;
    if (mode !== 2'd1) begin
      fails++;
      $display("FAIL midhold_entry: got mode %0d want 1", mode);
    end
    for (int i = 0; i < 45; i++) tick(1'b1, 1'b0);
    #2;
    Reset_N = 1'b0;
    #1;
    tests++;
    if (dv !== RST_VEC) begin
      fails++;
      $display("FAIL async_reset: got %b want %b", dv, RST_VEC);
    end
    model_reset();
    repeat (3) @(posedge sample_clk);
    #3;
    Reset_N = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(1'b1, 1'b0);
      if (inc_hour !== 1'b0 || inc_min !== 1'b0 ||
          clr_sec !== 1'b0 || dv !== exp_vec()) bad++;
    end
    tick(1'b1, 1'b1);
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL post_reset_hold: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_random();
    bit ka;
    bit km;
    int adj_left;
    int mode_low;
    int onehot_bad;
    ka = 1'b1;
    adj_left = 0;
    mode_low = 0;
    onehot_bad = 0;
    for (int i = 0; i < 5000; i++) begin
      if (adj_left == 0) begin
        ka = ~ka;
        adj_left = ka ? $urandom_range(1, 8) : $urandom_range(1, 70);
      end
      adj_left--;
      if (mode_low > 0) begin
        mode_low--;
      end else if ($urandom_range(0, (i < 2500) ? 40 : 700) == 0) begin
        mode_low = $urandom_range(1, 3);
      end
      km = (mode_low == 0);
      tick(km, ka);
      if ($countones({inc_hour, inc_min, clr_sec}) > 1) onehot_bad++;
      tests++;
      if (dv !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc %0d: got %b want %b",
                 i, dv, exp_vec());
      end
    end
    tests++;
    if (onehot_bad != 0) begin
      fails++;
      $display("FAIL strobe_onehot: got %0d cycles want 0", onehot_bad);
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_hold_repeat();
    test_sec_no_repeat();
    test_timeout();
    test_simultaneous();
    test_reset_midhold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
